alu_req_fifo: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_req_mem.sv | 26 ++
 rtl/alu_req_fifo.sv | 118 +++++++++++
 tb/tb_alu_req_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU request path: operand width, select
// encoding, the packed request record and the default request-buffer depth.
package alu_pkg;

    parameter int ALU_N = 64;
    localparam int ALU_REQ_DEPTH = 8;

    typedef logic [1:0] alu_sel_t;

    typedef struct packed {
        logic [ALU_N-1:0] op_a;
        logic [ALU_N-1:0] op_b;
        alu_sel_t         sel;
    } alu_req_t;

endpackage

// File: rtl/alu_req_mem.sv
// Request storage for alu_req_fifo: DEPTH x WIDTH array, one synchronous write
// port and one asynchronous read port so the head can fall through. Not reset.
module alu_req_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 130,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_req_fifo.sv
// First-word-fall-through request FIFO in front of the ALU operand inputs.
// Optional occupancy statistics (peak_count, drop_cnt) under ALU_REQ_FIFO_STATS_EN.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = ALU_REQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_op_a,
    input  logic [N-1:0]             in_op_b,
    input  logic [1:0]               in_sel,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic [N-1:0]             op_a,
    output logic [N-1:0]             op_b,
    output logic [1:0]               sel,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   peak_count,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = 2 * N + 2;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop;
    logic [W-1:0]  head_data;
    logic [N-1:0]  head_a, head_b;
    alu_sel_t      head_sel;

    // Full/empty derive from occupancy so pointers can wrap freely.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign alu_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = alu_valid && alu_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    alu_req_mem #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata ({in_op_a, in_op_b, in_sel}),
        .raddr (rd_ptr_reg),
        .rdata (head_data)
    );

    // Unwritten storage must never leak out, so the head is masked when empty.
    assign {head_a, head_b, head_sel} = head_data;
    assign op_a  = alu_valid ? head_a   : '0;
    assign op_b  = alu_valid ? head_b   : '0;
    assign sel   = alu_valid ? head_sel : '0;
    assign count = count_reg;

`ifdef ALU_REQ_FIFO_STATS_EN
    logic [CW-1:0] peak_count_reg;
    logic [15:0]   drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_count_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            if (count_reg > peak_count_reg) begin
                peak_count_reg <= count_reg;
            end
            if (in_valid && !in_ready && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign peak_count = peak_count_reg;
    assign drop_cnt   = drop_cnt_reg;
`else
    assign peak_count = '0;
    assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_alu_req_fifo.sv
// Scoreboard bench for alu_req_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based occupancy model. Honours ALU_REQ_FIFO_STATS_EN.
module tb_alu_req_fifo;

    localparam int N     = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_op_a;
    logic [N-1:0]  in_op_b;
    logic [1:0]    in_sel;
    logic          alu_valid;
    logic          alu_ready;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [1:0]    sel;
    logic [CW-1:0] count;
    logic [CW-1:0] peak_count;
    logic [15:0]   drop_cnt;

    int errors = 0;
    int checks = 0;

    alu_req_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op_a    (in_op_a),
        .in_op_b    (in_op_b),
        .in_sel     (in_sel),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sel        (sel),
        .count      (count),
        .peak_count (peak_count),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: occupancy as an integer, accepted requests as a queue.
    logic [2*N+1:0] sb_q[$];
    int model_cnt  = 0;
    int model_peak = 0;
    int model_drop = 0;
    logic push_ok, pop_ok;

    assign push_ok = in_valid && (model_cnt < DEPTH);
    assign pop_ok  = alu_ready && (model_cnt > 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_cnt  <= 0;
            model_peak <= 0;
            model_drop <= 0;
            sb_q.delete();
        end else begin
            if (model_cnt > model_peak) model_peak <= model_cnt;
            if (in_valid && !push_ok && model_drop < 65535) model_drop <= model_drop + 1;
            if (push_ok) sb_q.push_back({in_op_a, in_op_b, in_sel});
            model_cnt <= model_cnt + int'(push_ok) - int'(pop_ok);
        end
    end

    task automatic chk(input string name, input logic [2*N+1:0] act, input logic [2*N+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares status every cycle, head against the scoreboard, pops on transfer.
    always @(negedge clk) begin
        logic [2*N+1:0] exp_head;
        chk("count", (2*N+2)'(count), (2*N+2)'(model_cnt));
        chk("in_ready", (2*N+2)'(in_ready), (2*N+2)'(model_cnt < DEPTH));
        chk("alu_valid", (2*N+2)'(alu_valid), (2*N+2)'(model_cnt > 0));
`ifdef ALU_REQ_FIFO_STATS_EN
        chk("peak_count", (2*N+2)'(peak_count), (2*N+2)'(model_peak));
        chk("drop_cnt", (2*N+2)'(drop_cnt), (2*N+2)'(model_drop));
`else
        chk("peak_count_tied", (2*N+2)'(peak_count), '0);
        chk("drop_cnt_tied", (2*N+2)'(drop_cnt), '0);
`endif
        if (alu_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected: got valid head %0h expected none at %0t", op_a, $time);
            end else begin
                exp_head = sb_q[0];
                chk("head", {op_a, op_b, sel}, exp_head);
                if (alu_ready) begin
                    void'(sb_q.pop_front());
                    $display("pop a=%0h b=%0h sel=%0d", op_a, op_b, sel);
                end
            end
        end else begin
            chk("head_zero_when_empty", {op_a, op_b, sel}, '0);
        end
    end

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] s, input logic r);
        in_valid  = v;
        in_op_a   = a;
        in_op_b   = b;
        in_sel    = s;
        alu_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_op_a = 64'hDEAD;
        in_op_b = 64'hBEEF;
        in_sel = 2'd3;
        alu_ready = 1'b0;

        // Reset with in_valid held high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", (2*N+2)'(count), '0);
        chk("rst_in_ready", (2*N+2)'(in_ready), (2*N+2)'(1));
        chk("rst_head", {op_a, op_b, sel}, '0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single pass with a held head
        drive(1'b1, 64'd5, 64'd3, 2'd1, 1'b0);
        repeat (4) drive(1'b0, '0, '0, 2'd0, 1'b0);
        chk("single_held_op_a", (2*N+2)'(op_a), (2*N+2)'(5));
        drive(1'b0, '0, '0, 2'd0, 1'b1);
        chk("single_empty", (2*N+2)'(alu_valid), '0);

        // Fill to DEPTH, then one refused push, then drain
        for (int i = 0; i < 9; i++) drive(1'b1, 64'(i), ~64'(i), 2'(i), 1'b0);
        chk("fill_count", (2*N+2)'(count), (2*N+2)'(DEPTH));
        chk("fill_in_ready", (2*N+2)'(in_ready), '0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 2'd0, 1'b1);
        chk("drain_count", (2*N+2)'(count), '0);
`ifdef ALU_REQ_FIFO_STATS_EN
        chk("fill_drop_cnt", (2*N+2)'(drop_cnt), (2*N+2)'(1));
        chk("fill_peak", (2*N+2)'(peak_count), (2*N+2)'(DEPTH));
`endif

        // Concurrent push/pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) drive(1'b1, 64'(50 + i), 64'(i), 2'd2, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 64'(100 + i), 64'(7 * i), 2'(i), 1'b1);
        chk("concurrent_count", (2*N+2)'(count), (2*N+2)'(3));
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 2'd0, 1'b1);

        // Mid-operation reset
        for (int i = 0; i < 5; i++) drive(1'b1, 64'(200 + i), 64'(i), 2'd1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_count", (2*N+2)'(count), '0);
        chk("midrst_alu_valid", (2*N+2)'(alu_valid), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 64'd9, 64'd1, 2'd0, 1'b0);
        chk("midrst_push_op_a", (2*N+2)'(op_a), (2*N+2)'(9));
        drive(1'b0, '0, '0, 2'd0, 1'b1);

        // Pop attempts while empty must not disturb state
        repeat (3) drive(1'b0, '0, '0, 2'd0, 1'b1);
        chk("empty_pop_count", (2*N+2)'(count), '0);
        drive(1'b1, 64'h77, 64'h66, 2'd3, 1'b0);
        chk("empty_pop_head", (2*N+2)'(op_a), (2*N+2)'(64'h77));
        drive(1'b0, '0, '0, 2'd0, 1'b1);

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 8; ph++) begin
            int pv = (ph % 2 == 0) ? 80 : 25;
            int pr = (ph % 2 == 0) ? 30 : 85;
            for (int c = 0; c < 250; c++) begin
                drive(($urandom_range(0, 99) < pv), {$urandom, $urandom}, {$urandom, $urandom},
                      2'($urandom_range(0, 3)), ($urandom_range(0, 99) < pr));
            end
        end
        repeat (DEPTH + 2) drive(1'b0, '0, '0, 2'd0, 1'b1);
        chk("final_empty", (2*N+2)'(count), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
